// File: rtl/bit_scan_sequencer.sv
// -----------------------------------------------------------------------------
// bit_scan_sequencer
//
// Accepts a VAR_NUM-bit vector and emits the index of each set bit, one per
// output handshake. out_last marks the final pending bit of a vector. done
// pulses for one cycle once a vector has been fully consumed, including a
// vector that was all zero from the start.
//
// Scan order is selected at build time by the macro BIT_SCAN_ROTATE_EN:
//   undefined : the lowest-index pending bit is always emitted first.
//   defined   : a start pointer (ptr) is kept. The search runs upward from ptr
//               and wraps from VAR_NUM-1 to 0. After every output transfer
//               ptr moves to one past the emitted index. ptr survives across
//               vectors and is not touched by flush.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   load_valid  in   load_vec is offered
//   load_ready  out  high in IDLE: a new vector can be accepted
//   load_vec    in   [VAR_NUM]     set bits are the indices to emit
//   out_valid   out  high in SCAN: out_idx is valid
//   out_ready   in   consumer takes out_idx
//   out_idx     out  [VAR_NUM_LOG] selected index (0 when out_valid=0)
//   out_last    out  out_idx is the final pending bit (0 when out_valid=0)
//   flush       in   abandon the current vector (no done pulse)
//   done        out  one-cycle pulse when a vector is fully consumed
// -----------------------------------------------------------------------------
module bit_scan_sequencer #(
   parameter int VAR_NUM     = 8,
   parameter int VAR_NUM_LOG = $clog2(VAR_NUM)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [VAR_NUM-1:0]     load_vec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [VAR_NUM_LOG-1:0] out_idx,
   output logic                   out_last,
   input  logic                   flush,
   output logic                   done
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [VAR_NUM-1:0]     pending;
   logic [VAR_NUM-1:0]     pending_next;
   logic                   done_next;
   logic [VAR_NUM_LOG-1:0] sel_idx;

`ifdef BIT_SCAN_ROTATE_EN
   logic [VAR_NUM_LOG-1:0] ptr;
   logic [VAR_NUM_LOG-1:0] ptr_next;
   logic                   sel_found;

   // (base + ofs) mod VAR_NUM. Both inputs are below VAR_NUM, so one
   // conditional subtract is enough, and it also works when VAR_NUM is not a
   // power of two.
   function automatic logic [VAR_NUM_LOG-1:0] wrap_add(
      input logic [VAR_NUM_LOG-1:0] base,
      input int                     ofs
   );
      int sum;
      sum = int'(base) + ofs;
      if (sum >= VAR_NUM) sum = sum - VAR_NUM;
      return VAR_NUM_LOG'(sum);
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // Index selection: the first pending bit found from the start point.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // condition. A path that leaves a signal unassigned would infer a latch.
      sel_idx = '0;
`ifdef BIT_SCAN_ROTATE_EN
      sel_found = 1'b0;
      for (int i = 0; i < VAR_NUM; i++) begin
         if (!sel_found && pending[wrap_add(ptr, i)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_add(ptr, i);
         end
      end
`else
      // Walk downward so that the lowest set bit is the last one written.
      for (int i = VAR_NUM - 1; i >= 0; i--) begin
         if (pending[i]) sel_idx = VAR_NUM_LOG'(i);
      end
`endif
   end

   assign load_ready = (state == IDLE);
   assign out_valid  = (state == SCAN);
   assign out_idx    = out_valid ? sel_idx : '0;
   // In SCAN pending is never zero, so "one bit left" is exactly one-hot.
   assign out_last   = out_valid & $onehot(pending);

   // ---------------------------------------------------------------------------
   // Next-state logic. flush has priority over load and output handshakes.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      pending_next = pending;
      done_next    = 1'b0;
`ifdef BIT_SCAN_ROTATE_EN
      ptr_next     = ptr;
`endif
      if (flush) begin
         // Drop the vector silently. A load offered at the same time is lost.
         state_next   = IDLE;
         pending_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  pending_next = load_vec;
                  if (load_vec == '0) begin
                     // Nothing to emit, so the vector is consumed at once.
                     done_next = 1'b1;
                  end else begin
                     state_next = SCAN;
                  end
               end
            end
            SCAN: begin
               if (out_ready) begin
                  pending_next[sel_idx] = 1'b0;
`ifdef BIT_SCAN_ROTATE_EN
                  ptr_next = wrap_add(sel_idx, 1);
`endif
                  if (out_last) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset overrides flush, loads and handshakes.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples values from before the edge, whatever the statement order.
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
         done    <= 1'b0;
`ifdef BIT_SCAN_ROTATE_EN
         ptr     <= '0;
`endif
      end else begin
         state   <= state_next;
         pending <= pending_next;
         done    <= done_next;
`ifdef BIT_SCAN_ROTATE_EN
         ptr     <= ptr_next;
`endif
      end
   end

endmodule

// File: tb/tb_bit_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bit_scan_sequencer
//
// Directed test of bit_scan_sequencer with VAR_NUM=8. A reference model holds
// the pending indices of the current vector as an ordered queue and checks
// every DUT output on each falling edge. Literal sequence and done-count
// checks at the end of each scenario pin the model itself. The macro
// BIT_SCAN_ROTATE_EN selects the scan order here in the same way it does in
// the design.
// -----------------------------------------------------------------------------
module tb_bit_scan_sequencer;

   localparam int N = 8;
   localparam int W = $clog2(N);
`ifdef BIT_SCAN_ROTATE_EN
   localparam bit ROTATE = 1'b1;
`else
   localparam bit ROTATE = 1'b0;
`endif

   logic         clk        = 1'b0;
   logic         reset      = 1'b1;
   logic         load_valid = 1'b0;
   logic [N-1:0] load_vec   = '0;
   logic         out_ready  = 1'b0;
   logic         flush      = 1'b0;
   logic         load_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic         out_last;
   logic         done;

   bit_scan_sequencer #(.VAR_NUM(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_vec   (load_vec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .flush      (flush),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model. The queue holds the indices still to be emitted, in
   // emission order. They are computed once, when the vector is accepted, from
   // the start point (always 0 without rotation).
   // ---------------------------------------------------------------------------
   int q[$];
   int m_ptr  = 0;
   bit m_done = 1'b0;
   bit cmp_en = 1'b0;

   always @(posedge clk) begin
      int idx;
      int j;
      if (reset) begin
         q.delete();
         m_ptr  = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            q.delete();
         end else if (q.size() == 0) begin
            if (load_valid) begin
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (load_vec[j]) q.push_back(j);
               end
               m_done = (q.size() == 0);
            end
         end else if (out_ready) begin
            idx    = q.pop_front();
            m_ptr  = ROTATE ? (idx + 1) % N : 0;
            m_done = (q.size() == 0);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("load_ready", load_ready, (q.size() == 0));
         check("out_valid",  out_valid,  (q.size() != 0));
         check("out_idx",    out_idx,    (q.size() != 0) ? q[0] : 0);
         check("out_last",   out_last,   (q.size() == 1));
         check("done",       done,       m_done);
      end
   end

   // Observed transfers, packed one index per nibble, and done pulses.
   logic [31:0] seq_code = '0;
   int          seq_n    = 0;
   int          done_cnt = 0;

   always @(posedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         seq_code = (seq_code << 4) | 32'(out_idx);
         seq_n++;
      end
   end

   always @(negedge clk) begin
      if (cmp_en && done) done_cnt++;
   end

   // Inputs change just after the falling edge and are sampled at the next
   // rising edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_obs();
      seq_code = '0;
      seq_n    = 0;
      done_cnt = 0;
   endtask

   task automatic load(input logic [N-1:0] vec, input logic rdy);
      load_valid = 1'b1;
      load_vec   = vec;
      out_ready  = rdy;
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      reset = 1'b1;
      step();
      step();
      cmp_en = 1'b1;
      check("rst_load_ready", load_ready, 1);
      check("rst_out_valid",  out_valid,  0);
      check("rst_out_idx",    out_idx,    0);
      check("rst_done",       done,       0);
      reset = 1'b0;

      // 1010_0100 with out_ready=1 -> 2,5,7 back to back, then done.
      clr_obs();
      load(8'b1010_0100, 1'b1);
      check("a_first_idx", out_idx, 2);
      repeat (6) step();
      check("a_seq",   seq_code, 32'h257);
      check("a_count", seq_n,    3);
      check("a_done",  done_cnt, 1);
      check("a_ready", load_ready, 1);

      // All-zero vector: done one cycle after accept, never valid.
      clr_obs();
      load(8'h00, 1'b1);
      check("z_done_pulse", done,       1);
      check("z_valid",      out_valid,  0);
      check("z_ready",      load_ready, 1);
      step();
      check("z_done_low",   done,       0);
      check("z_count",      seq_n,      0);

      // Back-pressure: index 3 held for 3 cycles while a load is offered and
      // ignored. Then 3 and 4, with out_last on 4.
      clr_obs();
      load_valid = 1'b1;
      load_vec   = 8'b0001_1000;
      out_ready  = 1'b0;
      step();
      load_vec   = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         check("h_hold_idx",  out_idx,  3);
         check("h_hold_last", out_last, 0);
         step();
      end
      load_valid = 1'b0;
      out_ready  = 1'b1;
      step();
      check("h_second_idx",  out_idx,  4);
      check("h_second_last", out_last, 1);
      step();
      check("h_done_pulse", done, 1);
      repeat (2) step();
      check("h_seq",  seq_code, 32'h34);
      check("h_done", done_cnt, 1);

      // Flush in IDLE alongside a load: the load is dropped.
      clr_obs();
      load_valid = 1'b1;
      load_vec   = 8'h0F;
      flush      = 1'b1;
      step();
      load_valid = 1'b0;
      flush      = 1'b0;
      check("fi_ready", load_ready, 1);
      check("fi_valid", out_valid,  0);
      repeat (2) step();
      check("fi_count", seq_n,    0);
      check("fi_done",  done_cnt, 0);

      // 0xFF, flush after the second transfer: no done.
      clr_obs();
      load(8'hFF, 1'b1);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("f_valid", out_valid, 0);
      repeat (3) step();
      check("f_seq",   seq_code, ROTATE ? 32'h56 : 32'h01);
      check("f_count", seq_n,    2);
      check("f_done",  done_cnt, 0);

      // The next load is accepted normally.
      clr_obs();
      load(8'b1000_0001, 1'b1);
      repeat (4) step();
      check("n_seq",  seq_code, ROTATE ? 32'h70 : 32'h07);
      check("n_done", done_cnt, 1);

      // Reset mid-scan of 0xF0: outputs go to reset values, no done.
      clr_obs();
      load(8'hF0, 1'b1);
      step();
      reset = 1'b1;
      step();
      check("r_ready", load_ready, 1);
      check("r_valid", out_valid,  0);
      check("r_idx",   out_idx,    0);
      check("r_last",  out_last,   0);
      check("r_done",  done,       0);
      reset = 1'b0;
      step();
      check("r_seq",        seq_code, 32'h4);
      check("r_done_count", done_cnt, 0);

      // Pointer is back at 0 after reset: 1000_0001 -> 0 then 7.
      clr_obs();
      load(8'b1000_0001, 1'b1);
      repeat (4) step();
      check("p_seq", seq_code, 32'h07);

      // Emit index 5, then load 1000_0011.
      clr_obs();
      load(8'b0010_0000, 1'b1);
      repeat (3) step();
      check("o_first", seq_code, 32'h5);
      clr_obs();
      load(8'b1000_0011, 1'b1);
      repeat (5) step();
      check("o_seq",  seq_code, ROTATE ? 32'h701 : 32'h017);
      check("o_done", done_cnt, 1);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
